// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQUEST,
      SHIFT,
      ACK,
      WAITIDLE
   } ps2_state_t;

   localparam logic [3:0] PARITY_BIT = 4'd8;
   localparam logic [3:0] STOP_BIT   = 4'd9;
   localparam logic [1:0] RETRY_MAX  = 2'd2;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, glitch filter, falling-edge pulse.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic filt,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // idle PS/2 lines are pulled high, so reset to 1
   always_ff @(posedge clock) begin
      if (reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         filt <= 1'b1;
         cnt  <= '0;
         fall <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         fall <= 1'b0;
         if (s2 == filt) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt  <= '0;
            filt <= s2;
            fall <= filt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain via output enables).
// Define PS2_TX_RESEND_EN to retry a failed frame up to RETRY_MAX times.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 7000,
   parameter int TIMEOUT_CYCLES = 1050000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2ClkIn,
   input  logic       ps2DatIn,
   output logic       ps2ClkOe,
   output logic       ps2DatOe
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_t    state;
   logic [7:0]    shreg;
   logic          par;
   logic [3:0]    bitCnt;
   logic [IW-1:0] icnt;
   logic [TW-1:0] tcnt;
   logic          clk_f;
   logic          clk_fall;
   logic          dat_f;
   logic          dat_fall_unused;
   logic          wire_phase;
   logic          timeout;
   logic          nack;
   logic          fail;
`ifdef PS2_TX_RESEND_EN
   logic [1:0]    retry;
`endif

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
      .clock (clock),
      .reset (reset),
      .raw   (ps2ClkIn),
      .filt  (clk_f),
      .fall  (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat (
      .clock (clock),
      .reset (reset),
      .raw   (ps2DatIn),
      .filt  (dat_f),
      .fall  (dat_fall_unused)
   );

   assign wire_phase = (state == SHIFT) || (state == ACK) ||
                       (state == WAITIDLE);
   assign timeout = wire_phase && (tcnt == TMO_LAST);
   assign nack    = (state == ACK) && clk_fall && dat_f;
   assign fail    = timeout || nack;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         ps2ClkOe <= 1'b0;
         ps2DatOe <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
         bitCnt   <= '0;
         icnt     <= '0;
         tcnt     <= '0;
`ifdef PS2_TX_RESEND_EN
         retry    <= '0;
`endif
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         // zero on entry to REQUEST and on every device clock edge
         if (state == IDLE || state == INHIBIT || clk_fall)
            tcnt <= '0;
         else
            tcnt <= tcnt + 1'b1;

         unique case (state)
            IDLE: begin
               if (valid) begin
                  shreg    <= data;
                  par      <= odd_parity(data);
                  busy     <= 1'b1;
                  ps2ClkOe <= 1'b1;
                  icnt     <= '0;
`ifdef PS2_TX_RESEND_EN
                  retry    <= '0;
`endif
                  state    <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (icnt == INH_LAST) begin
                  ps2DatOe <= 1'b1;
                  state    <= REQUEST;
               end else begin
                  icnt <= icnt + 1'b1;
               end
            end
            REQUEST: begin
               ps2ClkOe <= 1'b0;
               bitCnt   <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (clk_fall) begin
                  bitCnt <= bitCnt + 1'b1;
                  if (bitCnt == STOP_BIT) begin
                     ps2DatOe <= 1'b0;
                     state    <= ACK;
                  end else if (bitCnt == PARITY_BIT) begin
                     ps2DatOe <= ~par;
                  end else begin
                     ps2DatOe <= ~shreg[bitCnt[2:0]];
                  end
               end
            end
            ACK: begin
               if (clk_fall && !dat_f)
                  state <= WAITIDLE;
            end
            WAITIDLE: begin
               if (clk_f && dat_f) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (fail) begin
            ps2ClkOe <= 1'b0;
            ps2DatOe <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            if (retry < RETRY_MAX) begin
               retry    <= retry + 1'b1;
               ps2ClkOe <= 1'b1;
               icnt     <= '0;
               state    <= INHIBIT;
            end else begin
               error <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
`else
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`endif
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with an open-drain device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 700;
   localparam int TMO = 3000;
   localparam int H   = 60;
   localparam int LIM = INH + TMO + 400;
`ifdef PS2_TX_RESEND_EN
   localparam int NF_FAIL = int'(RETRY_MAX) + 1;
`else
   localparam int NF_FAIL = 1;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       busy, done, error;
   logic       ps2ClkOe, ps2DatOe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       clk_line, dat_line;

   assign clk_line = ~ps2ClkOe & dev_clk;
   assign dat_line = ~ps2DatOe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_LEN     (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .data     (data),
      .valid    (valid),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .ps2ClkIn (clk_line),
      .ps2DatIn (dat_line),
      .ps2ClkOe (ps2ClkOe),
      .ps2DatOe (ps2DatOe)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic err;
      logic tmo;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] frame_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   longint      req_cyc = 0;
   int          inh_cnt = 0;

   always @(posedge clock) cyc++;

   task automatic chk(string name, logic [63:0] got, logic [63:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
      end
   endtask

   task automatic flag(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got event, required none", name);
   endtask

   // frame as the device sees it: start, data LSB first, odd parity, stop
   function automatic logic [10:0] ref_frame(logic [7:0] d);
      logic p;
      p = ($countones(d) % 2) == 0;
      return {1'b1, p, d, 1'b0};
   endfunction

   // monitor: inhibit length, outcome pulses, timeout distance
   always @(negedge clock) begin
      if (reset) begin
         inh_cnt = 0;
      end else begin
         if (ps2ClkOe && !ps2DatOe) begin
            inh_cnt++;
         end else begin
            if (ps2ClkOe && ps2DatOe && inh_cnt != 0) begin
               chk("inhibit_len", inh_cnt, INH);
               req_cyc = cyc;
            end
            inh_cnt = 0;
         end
         if (done || error) begin
            chk("done_err_excl", done & error, 0);
            chk("busy_drop", busy, 0);
            chk("lines_released", {ps2ClkOe, ps2DatOe}, 0);
            if (exp_q.size() == 0) begin
               flag("unexpected_pulse");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("outcome_err", error, e.err);
               if (e.tmo)
                  chk("timeout_len", cyc - req_cyc, TMO);
            end
         end
      end
   end

   // device: mode 0 = ACK, 1 = NACK, 2 = silent
   task automatic dev_frame(int mode, bit glitch, bit stop4);
      logic [10:0] bits;
      bit ok;
      ok = 0;
      for (int i = 0; i < LIM; i++) begin
         if (ps2ClkOe) begin ok = 1; break; end
         @(negedge clock);
      end
      if (!ok) begin flag("no_inhibit"); return; end
      ok = 0;
      for (int i = 0; i < LIM; i++) begin
         if (clk_line && !dat_line) begin ok = 1; break; end
         @(negedge clock);
      end
      if (!ok) begin flag("no_request"); return; end
      if (mode == 2) return;
      bits = '0;
      bits[0] = dat_line;
      for (int i = 1; i <= 10; i++) begin
         if (glitch && i == 6) begin
            repeat (20) @(negedge clock);
            dev_clk = 1'b0;
            repeat (3) @(negedge clock);
            dev_clk = 1'b1;
         end
         repeat (H) @(negedge clock);
         dev_clk = 1'b0;
         repeat (H) @(negedge clock);
         dev_clk = 1'b1;
         bits[i] = dat_line;
         if (stop4 && i == 4) return;
      end
      if (frame_q.size() == 0) flag("unexpected_frame");
      else chk("frame_bits", bits, frame_q.pop_front());
      dev_dat = (mode == 0) ? 1'b0 : 1'b1;
      repeat (H) @(negedge clock);
      dev_clk = 1'b0;
      repeat (H) @(negedge clock);
      dev_clk = 1'b1;
      repeat (H) @(negedge clock);
      dev_dat = 1'b1;
   endtask

   task automatic send(logic [7:0] d, int mode, bit glitch, bit inject);
      int nf;
      nf = (mode == 0) ? 1 : NF_FAIL;
      exp_q.push_back('{err: (mode != 0), tmo: (mode == 2)});
      if (mode != 2)
         for (int f = 0; f < nf; f++) frame_q.push_back(ref_frame(d));
      @(negedge clock);
      data  = d;
      valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
      data  = 8'($urandom);
      chk("accept_busy", busy, 1);
      chk("accept_clkoe", ps2ClkOe, 1);
      fork
         for (int f = 0; f < nf; f++) dev_frame(mode, glitch, 1'b0);
         if (inject) begin
            repeat (INH + 300) @(negedge clock);
            data  = (d == 8'h55) ? 8'hAA : 8'h55;
            valid = 1'b1;
            @(negedge clock);
            valid = 1'b0;
         end
      join
      for (int i = 0; i < LIM && busy; i++) @(negedge clock);
      chk("busy_low_after", busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_outs", {busy, done, error, ps2ClkOe, ps2DatOe}, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      chk("idle_outs", {busy, done, error, ps2ClkOe, ps2DatOe}, 0);

      send(8'hED, 0, 1'b0, 1'b0);
      send(8'h01, 0, 1'b0, 1'b0);
      send(8'h3C, 1, 1'b0, 1'b0);
      send(8'h77, 2, 1'b0, 1'b0);
      send(8'hFF, 0, 1'b0, 1'b1);
      send(8'h96, 0, 1'b1, 1'b0);

      // reset four bits into a frame
      @(negedge clock);
      data  = 8'hA5;
      valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
      dev_frame(0, 1'b0, 1'b1);
      repeat (20) @(negedge clock);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mid_rst_lines", {ps2ClkOe, ps2DatOe}, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (TMO + 200) @(negedge clock);
      chk("post_rst_idle", busy, 0);

      for (int r = 0; r < 6; r++) begin
         logic [7:0] d;
         int m;
         d = 8'($urandom);
         m = ($urandom_range(0, 3) == 0) ? 1 : 0;
         send(d, m, 1'b0, 1'($urandom_range(0, 1)));
      end

      repeat (50) @(negedge clock);
      chk("sb_outcomes_left", exp_q.size(), 0);
      chk("sb_frames_left", frame_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- It is the outbound counterpart of the ULA's PS/2 keyboard receiver.
- It sits beside the receiver on the shared ps2 open-drain pair, clocked by the 70 MHz system clock (`clock70`).
- It drives the lines only through output-enables; the top level ties pad = oe ? 0 : z.

Parameters:
- INHIBIT_CYCLES, 7000: clock-low inhibit time (100 us at 70 MHz).
- TIMEOUT_CYCLES, 1050000: max cycles waiting for any device clock edge (15 ms at 70 MHz).
- FILTER_LEN, 8: consecutive equal samples required before a filtered line changes.

Ports:
- clock  in  1  system clock (`clock70`).
- reset  in  1  synchronous, active-high reset.
- data  in  8  byte to send.
- valid  in  1  one-cycle send request; accepted only when busy=0.
- busy  out  1  high from the accept cycle until done/error.
- done  out  1  one-cycle pulse: frame acknowledged by the device.
- error  out  1  one-cycle pulse: NACK or timeout.
- ps2ClkIn  in  1  raw PS/2 clock pad.
- ps2DatIn  in  1  raw PS/2 data pad.
- ps2ClkOe  out  1  1 = pull PS/2 clock low.
- ps2DatOe  out  1  1 = pull PS/2 data low.

Behaviour:
- Reset, synchronous: all outputs 0, state IDLE, counters cleared. Reset mid-frame releases both lines on the next clock edge; no done/error pulse is issued.
- Line conditioning:
  - 2-FF synchronizer per line, then a FILTER_LEN-sample glitch filter.
  - fallClk = one-cycle pulse on a filtered clock 1->0.
- IDLE:
  - On valid=1, latch data and compute par = ~^data (odd parity).
  - busy=1 from the next cycle; go to INHIBIT.
  - valid while busy=1 is ignored; the latched byte is not changed.
- INHIBIT: ps2ClkOe=1 for exactly INHIBIT_CYCLES; then go to REQUEST.
- REQUEST:
  - One cycle with ps2DatOe=1 (start bit 0) and ps2ClkOe=1.
  - Next cycle ps2ClkOe=0; go to SHIFT with bitCnt=0.
  - ps2DatOe stays 1 until the first fallClk.
- SHIFT: on each fallClk, present the next bit. ps2DatOe = ~bit; ps2DatOe is constant between edges.
  - bitCnt 0..7 -> data[bitCnt], LSB first.
  - bitCnt 8 -> par.
  - bitCnt 9 -> stop bit 1 (ps2DatOe=0); go to ACK.
- ACK:
  - On the next fallClk, sample filtered data.
  - 0 -> go to WAITIDLE.
  - 1 -> NACK: error pulse, go to IDLE.
- WAITIDLE: wait until filtered clock=1 and data=1, then done pulse, busy=0, IDLE.
- Timeout:
  - Counter reloads on entry to REQUEST and on every fallClk.
  - Reaching TIMEOUT_CYCLES in SHIFT/ACK/WAITIDLE causes: release both lines, error pulse, IDLE.
- done and error never assert together; busy drops in the same cycle either pulses.
- The receiver must ignore frames while busy=1, i.e. the bits the host clocks out itself.
- Latency: accept to first line drive = 1 cycle; inhibit is exact to the cycle.

Optional Feature:
- Macro: PS2_TX_RESEND_EN.
- With it defined:
  - A NACK or timeout restarts from INHIBIT with the same byte, up to 2 retries.
  - error pulses only after the third failure.
  - busy stays high throughout.
  - The retry count is cleared on accept and on reset.
- Without it: the first NACK or timeout pulses error immediately.

Decomposition:
- Package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAITIDLE);
  - bit-index constants (PARITY_BIT=8, STOP_BIT=9);
  - the retry limit constant (2).
- Sub-module ps2_line_filter: synchronizer + glitch filter + falling-edge pulse, instantiated per line. The receiver can reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz:
  - required: clock low for exactly 7000 cycles;
  - bits seen by the device = 0,1,0,1,1,0,1,1,1, parity 1, stop 1;
  - ACK=0 -> one done pulse; busy low afterwards.
- Send 0x01: parity bit 0 -> done.
- Device drives ACK=1 (NACK):
  - without macro -> one error pulse, lines released;
  - with PS2_TX_RESEND_EN -> 3 full frames, then error.
- No device clock after REQUEST -> error exactly TIMEOUT_CYCLES after the REQUEST entry; ps2ClkOe=ps2DatOe=0.
- valid=1 with 0x55 during a 0xFF frame -> ignored; 0xFF is transmitted intact.
- Glitches and reset:
  - 3-cycle low glitch on the clock mid-frame -> no extra bit shifted.
  - reset asserted at bitCnt=4 -> both Oe=0 and busy=0 next cycle; no done/error.
